// File: rtl/demux_pkg.sv
// demux_pkg: slot width, slot constants and lock-state encoding shared by the TDM demux
package demux_pkg;
    localparam int SLOT_W = 2;
    typedef logic [SLOT_W-1:0] slot_t;
    localparam slot_t SLOT0 = 2'b00;
    localparam slot_t SLOT1 = 2'b01;
    localparam slot_t SLOT2 = 2'b10;
    localparam slot_t SLOT3 = 2'b11;
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
endpackage

// File: rtl/demux_slot_ctr.sv
// demux_slot_ctr: slot counter, lock state and sync_err for the TDM demux
//   in : clk, rst_n, din_valid, sync
//   out: slot (next slot to fill), locked, sync_err (registered pulse),
//        wr_en/wr_idx (beat accepted and its slot), frame_done (slot-3 beat closes a frame)
module demux_slot_ctr
    import demux_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  din_valid,
    input  logic  sync,
    output slot_t slot,
    output logic  locked,
    output logic  sync_err,
    output logic  wr_en,
    output slot_t wr_idx,
    output logic  frame_done
);
    logic [0:0] state_q, state_d;
    slot_t      slot_q, slot_d;
    logic       sync_err_q, sync_err_d;
    logic       sync_beat;

    always_comb begin
        sync_beat  = din_valid && sync;
        wr_en      = din_valid && (state_q == ST_LOCKED || sync);
        wr_idx     = sync ? SLOT0 : slot_q;
        // a sync beat is always slot 0, so it can never close a frame
        frame_done = wr_en && !sync && slot_q == SLOT3;
        state_d    = sync_beat ? ST_LOCKED : state_q;
        slot_d     = !wr_en ? slot_q : sync ? SLOT1 : slot_q + SLOT1;
        sync_err_d = sync_beat && state_q == ST_LOCKED && slot_q != SLOT0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNLOCKED;
            slot_q     <= SLOT0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign slot     = slot_q;
    assign locked   = state_q == ST_LOCKED;
    assign sync_err = sync_err_q;
endmodule

// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: rebuilds four parallel channels from a 4-way slot-interleaved word stream
//   in : clk, rst_n, din[N], din_valid, sync (marks slot 0)
//   out: Q3..Q0 (last complete frame), frame_valid (pulse), slot, locked, sync_err
module demux1to4_tdm
    import demux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    input  logic         sync,
    output logic [N-1:0] Q3,
    output logic [N-1:0] Q2,
    output logic [N-1:0] Q1,
    output logic [N-1:0] Q0,
    output logic         frame_valid,
    output logic [1:0]   slot,
    output logic         locked,
    output logic         sync_err
);
    logic         wr_en, frame_done;
    slot_t        wr_idx;
    logic [N-1:0] shadow_q [0:2];
    logic [N-1:0] shadow_d [0:2];
    logic [N-1:0] q_q [0:3];
    logic [N-1:0] q_d [0:3];
    logic         frame_valid_q, frame_valid_d;

    demux_slot_ctr u_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .sync       (sync),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .frame_done (frame_done)
    );

    // slot 3 bypasses the shadows and lands directly in Q3 with the rest of the frame
    always_comb begin
        shadow_d      = shadow_q;
        q_d           = q_q;
        frame_valid_d = frame_done;
        for (int i = 0; i < 3; i++)
            if (wr_en && wr_idx == SLOT_W'(i)) shadow_d[i] = din;
        if (frame_done) begin
            for (int i = 0; i < 3; i++) q_d[i] = shadow_q[i];
            q_d[3] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
            for (int i = 0; i < 4; i++) q_q[i] <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            q_q           <= q_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign Q0          = q_q[0];
    assign Q1          = q_q[1];
    assign Q2          = q_q[2];
    assign Q3          = q_q[3];
    assign frame_valid = frame_valid_q;
endmodule

// File: tb/tb_demux1to4_tdm.sv
// tb_demux1to4_tdm: directed self-checking bench for demux1to4_tdm with N=4
module tb_demux1to4_tdm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] Q3, Q2, Q1, Q0;
    logic       frame_valid, locked, sync_err;
    logic [1:0] slot;
    int         n_chk = 0;
    int         n_fail = 0;

    demux1to4_tdm #(.N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .Q3          (Q3),
        .Q2          (Q2),
        .Q1          (Q1),
        .Q0          (Q0),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                         input logic [3:0] e2, input logic [3:0] e3);
        chk({tag, ".Q0"}, 32'(Q0), 32'(e0));
        chk({tag, ".Q1"}, 32'(Q1), 32'(e1));
        chk({tag, ".Q2"}, 32'(Q2), 32'(e2));
        chk({tag, ".Q3"}, 32'(Q3), 32'(e3));
    endtask

    task automatic chk_st(input string tag, input logic fv, input logic [1:0] sl,
                          input logic lk, input logic se);
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(fv));
        chk({tag, ".slot"}, 32'(slot), 32'(sl));
        chk({tag, ".locked"}, 32'(locked), 32'(lk));
        chk({tag, ".sync_err"}, 32'(sync_err), 32'(se));
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic [3:0] d, input logic v, input logic s);
        @(negedge clk);
        din = d;
        din_valid = v;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        sync = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_q("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_st("reset", 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic frame
        step(4'h1, 1'b1, 1'b1); chk_st("f1.b0", 1'b0, 2'd1, 1'b1, 1'b0);
        step(4'h3, 1'b1, 1'b0); chk_st("f1.b1", 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'h7, 1'b1, 1'b0); chk_st("f1.b2", 1'b0, 2'd3, 1'b1, 1'b0);
        chk_q("f1.b2", 4'h0, 4'h0, 4'h0, 4'h0);
        step(4'hF, 1'b1, 1'b0); chk_st("f1.b3", 1'b1, 2'd0, 1'b1, 1'b0);
        chk_q("f1", 4'h1, 4'h3, 4'h7, 4'hF);
        step(4'h0, 1'b0, 1'b0); chk_st("f1.idle", 1'b0, 2'd0, 1'b1, 1'b0);

        // pre-sync beats are discarded
        do_reset();
        step(4'h5, 1'b1, 1'b0); chk_st("pre.0", 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'hA, 1'b1, 1'b0); chk_st("pre.1", 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'hC, 1'b1, 1'b0); chk_st("pre.2", 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 1'b1); chk_st("pre.nov", 1'b0, 2'd0, 1'b0, 1'b0);
        step(4'hA, 1'b1, 1'b1); chk_st("f2.b0", 1'b0, 2'd1, 1'b1, 1'b0);
        step(4'hB, 1'b1, 1'b0);
        step(4'hC, 1'b1, 1'b0);
        step(4'hD, 1'b1, 1'b0); chk_st("f2.b3", 1'b1, 2'd0, 1'b1, 1'b0);
        chk_q("f2", 4'hA, 4'hB, 4'hC, 4'hD);

        // 2-cycle gap between slots 1 and 2; sync without valid has no effect
        step(4'h1, 1'b1, 1'b1); chk_st("f3.b0", 1'b0, 2'd1, 1'b1, 1'b0);
        step(4'h3, 1'b1, 1'b0); chk_st("f3.b1", 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'h9, 1'b0, 1'b1); chk_st("f3.gap0", 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'h9, 1'b0, 1'b0); chk_st("f3.gap1", 1'b0, 2'd2, 1'b1, 1'b0);
        chk_q("f3.gap", 4'hA, 4'hB, 4'hC, 4'hD);
        step(4'h7, 1'b1, 1'b0); chk_st("f3.b2", 1'b0, 2'd3, 1'b1, 1'b0);
        step(4'hF, 1'b1, 1'b0); chk_st("f3.b3", 1'b1, 2'd0, 1'b1, 1'b0);
        chk_q("f3", 4'h1, 4'h3, 4'h7, 4'hF);

        // resync mid-frame
        step(4'h6, 1'b1, 1'b0);
        step(4'h9, 1'b1, 1'b0); chk_st("rs.b1", 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'hE, 1'b1, 1'b1); chk_st("rs.sync", 1'b0, 2'd1, 1'b1, 1'b1);
        chk_q("rs.sync", 4'h1, 4'h3, 4'h7, 4'hF);
        step(4'h2, 1'b1, 1'b0); chk_st("rs.b1b", 1'b0, 2'd2, 1'b1, 1'b0);
        step(4'h4, 1'b1, 1'b0);
        step(4'h8, 1'b1, 1'b0); chk_st("rs.b3", 1'b1, 2'd0, 1'b1, 1'b0);
        chk_q("rs", 4'hE, 4'h2, 4'h4, 4'h8);
        step(4'h5, 1'b1, 1'b1); chk_st("rs.s0ok", 1'b0, 2'd1, 1'b1, 1'b0);
        step(4'h0, 1'b0, 1'b0);

        // async reset mid-frame, after slot 2
        do_reset();
        step(4'h1, 1'b1, 1'b1);
        step(4'h2, 1'b1, 1'b0);
        step(4'h3, 1'b1, 1'b0); chk_st("ar.pre", 1'b0, 2'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_q("ar", 4'h0, 4'h0, 4'h0, 4'h0);
        chk_st("ar", 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'h4, 1'b1, 1'b0); chk_st("ar.nosync", 1'b0, 2'd0, 1'b0, 1'b0);
        chk_q("ar.nosync", 4'h0, 4'h0, 4'h0, 4'h0);

        // three back-to-back frames
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                step(4'(k * 4 + i), 1'b1, i == 0);
                chk("b2b.frame_valid", 32'(frame_valid), 32'(i == 3));
                chk("b2b.slot", 32'(slot), 32'((i + 1) % 4));
            end
        chk_q("b2b", 4'h8, 4'h9, 4'hA, 4'hB);
        step(4'h0, 1'b0, 1'b0); chk_st("b2b.end", 1'b0, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
